operation_encoder: RTL and testbench
====================================

# operation_encoder

Converts decoded keyboard make/break events into the `operation_code`/`boost` command pair consumed by the physics engine once per clock. Keeps a held-key table, resolves conflicting keys, and paces turn commands so a held turn key advances the car's angle at a fixed rate rather than every cycle. It sits between the keyboard scan-code front end and the physics engine, and is gated by the game state from the state encoder.

## Interface
- `TURN_PERIOD`, 16'd5000: cycles between successive LEFT/RIGHT pulses while a turn key is held; legal range ≥2.
- `RACE_STATE`, 3'd2: value of `state` during which commands are emitted.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `state` input 3: current game state from the state encoder.
- `key_valid` input 1: one-cycle strobe; `key_code`, `key_extended` and `key_break` are valid while it is high.
- `key_code` input 8: scan-code set 2 make code.
- `key_extended` input 1: event carried an E0 prefix.
- `key_break` input 1: 1 means release, 0 means press.
- `operation_code` output 3: NIL=0, FORWARD=1, BACKWARD=2, LEFT=3, RIGHT=4, registered.
- `boost` output 1: registered.
- `held_keys` output 5: {shift, right, left, back, fwd} held-key table, registered.

## Operation
- Key map: W (8'h1D, not extended) drives fwd. S (8'h1B) drives back. A (8'h1C) drives left. D (8'h23) drives right. Left Shift (8'h12, not extended) drives shift.
- Any other code or extended combination is ignored. A break for a key that is not held has no effect. A make for a key already held (typematic repeat) has no effect.
- Turn resolution:
  - `turn_req` = left XOR right. Both held, or neither held, means no turn.
  - `turn_cnt` has width $clog2(TURN_PERIOD). It is cleared whenever `turn_req`=0.
  - When `turn_req`=1 and `turn_cnt`=0: emit the turn command and load TURN_PERIOD-1.
  - When `turn_req`=1 and `turn_cnt`≠0: decrement `turn_cnt`.
- Priority for the next `operation_code`:
  1. Turn pulse (from the turn resolution above).
  2. FORWARD if fwd and not back.
  3. BACKWARD if back and not fwd.
  4. NIL.
- Next `boost` = shift AND (next `operation_code` ≠ NIL).
- State gating: when `state` ≠ RACE_STATE:
  - Next `operation_code`=NIL and `boost`=0.
  - `turn_cnt` is held at 0.
  - The key table keeps updating.

## Timing
- Reset (`rst`=0, asynchronous): `operation_code`=NIL, `boost`=0, `held_keys`=0, `turn_cnt`=0.
- Deassertion of `rst` is synchronized by the top level; this block places no requirement on it.
- Key event at edge N updates `held_keys` at edge N. `operation_code` and `boost` reflect that update at edge N+1 (2-edge latency, event to command).
- A turn pulse lasts exactly 1 cycle.
- With a turn key held continuously, pulses repeat every TURN_PERIOD cycles. Drive commands fill the cycles between pulses.
- Opposing turn key pressed while one is held: `turn_req` drops, `turn_cnt` clears, LEFT/RIGHT stop on the next edge.
- `state` leaves RACE_STATE: outputs go NIL/0 on the next edge.
- Reset mid-turn: counter cleared. The first turn after reset is emitted immediately once the key is pressed again.

## Configuration
- `OPENC_ARROW_KEYS_EN` defined: arrow keys also map, all extended:
  - Up (8'h75) drives fwd.
  - Down (8'h72) drives back.
  - Left (8'h6B) drives left.
  - Right (8'h74) drives right.
  - Each arrow shares the held bit of its WASD twin, so releasing either twin clears the bit.
- `OPENC_ARROW_KEYS_EN` undefined: extended codes are ignored entirely; WASD and Shift only.

## Test plan
- Reset, then `state`=RACE_STATE, press W at edge 10 → `operation_code`=1 from edge 11, `boost`=0. Release W → NIL two edges after the release event.
- Hold W and Left Shift → `operation_code`=1, `boost`=1. Hold Shift alone → `boost`=0.
- TURN_PERIOD=4, hold A from edge 20 → LEFT at edges 21, 25, 29. NIL on the cycles between.
- Hold W+S → NIL. Hold A+D → NIL with no pulses. Release D → LEFT on the next edge after the table update.
- Hold D with `state`=0 → NIL. Switch `state` to RACE_STATE → RIGHT one edge later.
- Assert `rst`=0 mid-hold → all outputs 0 immediately, without waiting for a clock edge. Extended 8'h6B press → LEFT only when `OPENC_ARROW_KEYS_EN` is defined.

Source files
------------

// File: rtl/operation_encoder_if.sv
// Keyboard-event and command bundle between the scan-code front end, the
// operation_encoder and the physics engine.
interface operation_encoder_if;
  logic [2:0] state;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_break;
  logic [2:0] operation_code;
  logic       boost;
  logic [4:0] held_keys;

  modport master (
    output state, key_valid, key_code, key_extended, key_break,
    input  operation_code, boost, held_keys
  );

  modport slave (
    input  state, key_valid, key_code, key_extended, key_break,
    output operation_code, boost, held_keys
  );
endinterface

// File: rtl/operation_encoder.sv
// Turns keyboard make/break events into paced operation_code/boost commands.
// Optional feature: define OPENC_ARROW_KEYS_EN to map the extended arrow keys onto WASD.
module operation_encoder #(
  parameter int unsigned TURN_PERIOD = 16'd5000,
  parameter logic [2:0]  RACE_STATE  = 3'd2
) (
  input logic                clk,
  input logic                rst,
  operation_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(TURN_PERIOD);

  typedef enum logic [2:0] {
    OP_NIL   = 3'd0,
    OP_FWD   = 3'd1,
    OP_BACK  = 3'd2,
    OP_LEFT  = 3'd3,
    OP_RIGHT = 3'd4
  } op_e;

  localparam int K_FWD   = 0;
  localparam int K_BACK  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_SHIFT = 4;

  logic [4:0]       held_d, held_q;
  logic [4:0]       key_mask;
  logic [CNT_W-1:0] turn_cnt_d, turn_cnt_q;
  op_e              op_d, op_q;
  logic             boost_d, boost_q;
  logic             turn_req;

  // Key decode: extended codes only matter when the arrow map is built in
  always_comb begin
    key_mask = '0;
    if (!bus.key_extended) begin
      case (bus.key_code)
        8'h1D:   key_mask = 5'b00001;
        8'h1B:   key_mask = 5'b00010;
        8'h1C:   key_mask = 5'b00100;
        8'h23:   key_mask = 5'b01000;
        8'h12:   key_mask = 5'b10000;
        default: key_mask = '0;
      endcase
    end else begin
`ifdef OPENC_ARROW_KEYS_EN
      case (bus.key_code)
        8'h75:   key_mask = 5'b00001;
        8'h72:   key_mask = 5'b00010;
        8'h6B:   key_mask = 5'b00100;
        8'h74:   key_mask = 5'b01000;
        default: key_mask = '0;
      endcase
`else
      key_mask = '0;
`endif
    end
  end

  always_comb begin
    held_d = held_q;
    if (bus.key_valid) begin
      held_d = bus.key_break ? (held_q & ~key_mask) : (held_q | key_mask);
    end
  end

  // Commands come from the registered table, giving event-to-command latency of two edges
  assign turn_req = held_q[K_LEFT] ^ held_q[K_RIGHT];

  always_comb begin
    op_d       = OP_NIL;
    turn_cnt_d = '0;
    if (bus.state == RACE_STATE) begin
      if (turn_req) begin
        if (turn_cnt_q == '0) begin
          op_d       = held_q[K_LEFT] ? OP_LEFT : OP_RIGHT;
          turn_cnt_d = CNT_W'(TURN_PERIOD - 1);
        end else begin
          turn_cnt_d = turn_cnt_q - CNT_W'(1);
        end
      end
      if (op_d == OP_NIL) begin
        if (held_q[K_FWD] && !held_q[K_BACK]) begin
          op_d = OP_FWD;
        end else if (held_q[K_BACK] && !held_q[K_FWD]) begin
          op_d = OP_BACK;
        end
      end
    end
    boost_d = held_q[K_SHIFT] && (op_d != OP_NIL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q     <= '0;
      turn_cnt_q <= '0;
      op_q       <= OP_NIL;
      boost_q    <= 1'b0;
    end else begin
      held_q     <= held_d;
      turn_cnt_q <= turn_cnt_d;
      op_q       <= op_d;
      boost_q    <= boost_d;
    end
  end

  assign bus.operation_code = op_q;
  assign bus.boost          = boost_q;
  assign bus.held_keys      = held_q;

endmodule

// File: tb/tb_operation_encoder.sv
// Bench for operation_encoder: directed scenarios with literal expectations plus
// randomized key traffic compared every cycle against a behavioural model.
module tb_operation_encoder;

  localparam int         P    = 4;
  localparam logic [2:0] RACE = 3'd2;
  localparam int I_FWD = 0, I_BACK = 1, I_LEFT = 2, I_RIGHT = 3, I_SHIFT = 4;

  logic clk = 1'b0;
  logic rst_n;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;

  operation_encoder_if bus ();

  operation_encoder #(.TURN_PERIOD(P), .RACE_STATE(RACE)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: which logical key an event names, per the key map.
  function automatic logic [4:0] apply_key(input logic [4:0] h, input bit v,
                                           input logic [7:0] c, input bit e, input bit br);
    logic [4:0] m;
    m = '0;
    if (!e) begin
      if (c == 8'h1D) m[I_FWD] = 1'b1;
      if (c == 8'h1B) m[I_BACK] = 1'b1;
      if (c == 8'h1C) m[I_LEFT] = 1'b1;
      if (c == 8'h23) m[I_RIGHT] = 1'b1;
      if (c == 8'h12) m[I_SHIFT] = 1'b1;
    end else begin
`ifdef OPENC_ARROW_KEYS_EN
      if (c == 8'h75) m[I_FWD] = 1'b1;
      if (c == 8'h72) m[I_BACK] = 1'b1;
      if (c == 8'h6B) m[I_LEFT] = 1'b1;
      if (c == 8'h74) m[I_RIGHT] = 1'b1;
`endif
    end
    if (!v) return h;
    return br ? (h & ~m) : (h | m);
  endfunction

  // run = number of consecutive racing edges a single turn key has been held;
  // a pulse is due on every P-th such edge starting with the first.
  function automatic int model_op(input logic [4:0] h, input int run, input bit race);
    if (!race) return 0;
    if ((h[I_LEFT] != h[I_RIGHT]) && (run % P == 0)) return h[I_LEFT] ? 3 : 4;
    if (h[I_FWD] && !h[I_BACK]) return 1;
    if (h[I_BACK] && !h[I_FWD]) return 2;
    return 0;
  endfunction

  logic [4:0] m_held;
  int         run_len;
  int         exp_op;
  bit         exp_boost;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held    <= '0;
      run_len   <= 0;
      exp_op    <= 0;
      exp_boost <= 1'b0;
    end else begin
      exp_op    <= model_op(m_held, run_len, bus.state == RACE);
      exp_boost <= m_held[I_SHIFT] && (model_op(m_held, run_len, bus.state == RACE) != 0);
      run_len   <= ((bus.state == RACE) && (m_held[I_LEFT] != m_held[I_RIGHT])) ? run_len + 1 : 0;
      m_held    <= apply_key(m_held, bus.key_valid, bus.key_code, bus.key_extended, bus.key_break);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_op", int'(bus.operation_code), exp_op);
      chk("model_boost", int'(bus.boost), int'(exp_boost));
      chk("model_held", int'(bus.held_keys), int'(m_held));
    end
  end

  // Called at a falling edge; the event is taken on the following rising edge.
  task automatic key(input logic [7:0] c, input bit e, input bit br);
    bus.key_valid    = 1'b1;
    bus.key_code     = c;
    bus.key_extended = e;
    bus.key_break    = br;
    @(negedge clk);
    bus.key_valid    = 1'b0;
  endtask

  logic [7:0] pool [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h12,
                            8'h75, 8'h72, 8'h6B, 8'h74, 8'h29};

  initial begin
    bus.state        = 3'd0;
    bus.key_valid    = 1'b0;
    bus.key_code     = 8'h00;
    bus.key_extended = 1'b0;
    bus.key_break    = 1'b0;
    rst_n            = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_op", int'(bus.operation_code), 0);
    chk("reset_boost", int'(bus.boost), 0);
    chk("reset_held", int'(bus.held_keys), 0);
    bus.state = RACE;
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    key(8'h1D, 1'b0, 1'b0);
    chk("w_held", int'(bus.held_keys), 5'b00001);
    chk("w_latency", int'(bus.operation_code), 0);
    @(negedge clk);
    chk("w_fwd", int'(bus.operation_code), 1);
    chk("w_noboost", int'(bus.boost), 0);
    key(8'h12, 1'b0, 1'b0);
    @(negedge clk);
    chk("shift_fwd", int'(bus.operation_code), 1);
    chk("shift_boost", int'(bus.boost), 1);
    key(8'h1D, 1'b0, 1'b1);
    chk("w_rel_edge1", int'(bus.operation_code), 1);
    @(negedge clk);
    chk("w_rel_nil", int'(bus.operation_code), 0);
    chk("shift_alone", int'(bus.boost), 0);
    key(8'h12, 1'b0, 1'b1);

    key(8'h1C, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("left_pace_%0d", i), int'(bus.operation_code), (i % P == 1) ? 3 : 0);
    end
    key(8'h23, 1'b0, 1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("ad_nil", int'(bus.operation_code), 0);
    end
    key(8'h23, 1'b0, 1'b1);
    chk("d_rel_edge1", int'(bus.operation_code), 0);
    @(negedge clk);
    chk("d_rel_left", int'(bus.operation_code), 3);
    key(8'h1C, 1'b0, 1'b1);

    key(8'h1D, 1'b0, 1'b0);
    key(8'h1B, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("ws_nil", int'(bus.operation_code), 0);
    end
    key(8'h1D, 1'b0, 1'b1);
    key(8'h1B, 1'b0, 1'b1);

    bus.state = 3'd0;
    key(8'h23, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("gated_nil", int'(bus.operation_code), 0);
    end
    chk("gated_held", int'(bus.held_keys), 5'b01000);
    bus.state = RACE;
    @(negedge clk);
    chk("race_right", int'(bus.operation_code), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_op", int'(bus.operation_code), 0);
    chk("async_rst_held", int'(bus.held_keys), 0);
    chk("async_rst_boost", int'(bus.boost), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    key(8'h23, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_right", int'(bus.operation_code), 4);
    key(8'h23, 1'b0, 1'b1);

    key(8'h6B, 1'b1, 1'b0);
`ifdef OPENC_ARROW_KEYS_EN
    chk("arrow_held", int'(bus.held_keys), 5'b00100);
    @(negedge clk);
    chk("arrow_left", int'(bus.operation_code), 3);
`else
    chk("arrow_held", int'(bus.held_keys), 0);
    @(negedge clk);
    chk("arrow_left", int'(bus.operation_code), 0);
`endif
    key(8'h1C, 1'b0, 1'b1);
    chk("twin_release", int'(bus.held_keys), 0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      bus.key_valid    = ($urandom_range(0, 99) < 30);
      bus.key_code     = pool[$urandom_range(0, 9)];
      bus.key_extended = ($urandom_range(0, 3) == 0);
      bus.key_break    = ($urandom_range(0, 1) == 1);
      bus.state        = ($urandom_range(0, 9) < 8) ? RACE : 3'($urandom_range(0, 7));
      rst_n            = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    #1;
    bus.key_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
